// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
//   Shared definitions for the EHXPLLL dynamic phase controller: controller
//   state encoding, PHASESEL channel codes and the phase-counter width rule.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        IDLE,
        SETUP,
        STEP,
        GAP
    } pll_state_e;

    // PHASESEL codes as decoded by the EHXPLLL primitive.
    localparam logic [1:0] SEL_CLKOS  = 2'd0;
    localparam logic [1:0] SEL_CLKOS2 = 2'd1;
    localparam logic [1:0] SEL_CLKOS3 = 2'd2;
    localparam logic [1:0] SEL_CLKOP  = 2'd3;

    // Width of one per-channel phase counter; never narrower than 1 bit.
    function automatic int unsigned phase_w(input int unsigned modulus);
        if (modulus <= 2) begin
            return 1;
        end
        return $clog2(modulus);
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// pll_phase_ctrl_if
//   Phase-step request handshake.
//   req_valid  : requester has a request
//   req_ready  : controller can accept (IDLE)
//   req_ch     : output to steer (PHASESEL code)
//   req_dir    : 1 = advance, 0 = retard
//   req_count  : number of phase steps
interface pll_phase_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_ch;
    logic             req_dir;
    logic [CNT_W-1:0] req_count;

    modport master (
        output req_valid,
        output req_ch,
        output req_dir,
        output req_count,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ch,
        input  req_dir,
        input  req_count,
        output req_ready
    );
endinterface

// File: rtl/pll_lock_filter.sv
// pll_lock_filter
//   Synchronises the asynchronous EHXPLLL LOCK, qualifies it with a run of
//   LOCK_FILTER consecutive locked cycles, and flags loss of lock.
//   clk, reset_n : clock, synchronous active-low reset
//   pll_lock     : raw LOCK from the PLL
//   count_en     : controller is waiting for lock
//   armed        : controller currently reports ready
//   lock_ok      : last qualifying locked cycle (combinational)
//   lock_lost    : synchronised lock low while armed (combinational)
module pll_lock_filter #(
    parameter int unsigned LOCK_FILTER = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    input  logic count_en,
    input  logic armed,
    output logic lock_ok,
    output logic lock_lost
);
    localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          lock_s;

    always_comb begin
        sync1_d   = pll_lock;
        sync2_d   = sync1_q;
        lock_s    = sync2_q;
        lock_ok   = count_en && lock_s && (cnt_q == FW'(LOCK_FILTER - 1));
        lock_lost = armed && !lock_s;
        // Any unlocked cycle, or leaving the wait, restarts the run.
        if (count_en && lock_s && !lock_ok) begin
            cnt_d = cnt_q + FW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl
//   Drives the EHXPLLL dynamic phase-shift port: resets the PLL, waits for a
//   filtered lock, then executes step requests as PHASESTEP low pulses while
//   tracking the phase of each steerable output. Loss of lock aborts any
//   sequence, clears the phase trackers and restarts the PLL.
//   clk, reset_n          : clock, synchronous active-low reset
//   req (slave)           : step request handshake
//   pll_lock              : asynchronous LOCK from the PLL
//   phasesel/phasedir     : channel and direction, stable during a sequence
//   phasestep             : active-low step strobe, idles high
//   phaseloadreg          : held high
//   pll_rst               : PLL reset
//   ready/busy            : locked / sequence in progress
//   done/err              : one-cycle completion / bad-channel pulses
//   phase                 : packed per-channel phase counters
//   lock_loss_cnt         : saturating lock-loss counter
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PHASE_MOD   = 64,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned STEP_HI     = 4,
    parameter int unsigned STEP_GAP    = 4,
    parameter int unsigned LOCK_FILTER = 1024,
    parameter int unsigned RST_CYCLES  = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    pll_phase_ctrl_if.slave                       req,
    input  logic                                  pll_lock,
    output logic [1:0]                            phasesel,
    output logic                                  phasedir,
    output logic                                  phasestep,
    output logic                                  phaseloadreg,
    output logic                                  pll_rst,
    output logic                                  ready,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    output logic [NUM_CH*phase_w(PHASE_MOD)-1:0]  phase,
    output logic [7:0]                            lock_loss_cnt
);
    localparam int unsigned PHASE_W = phase_w(PHASE_MOD);
    localparam int unsigned TMR_MAX = (STEP_HI > STEP_GAP) ? STEP_HI : STEP_GAP;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned RC_W    = $clog2(RST_CYCLES + 1);

    pll_state_e                     state_q, state_d;
    logic [RC_W-1:0]                rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0]               tmr_q, tmr_d;
    logic [CNT_W-1:0]               rem_q, rem_d;
    logic [NUM_CH-1:0][PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]                     loss_q, loss_d;
    logic [1:0]                     phasesel_q, phasesel_d;
    logic                           phasedir_q, phasedir_d;
    logic                           phasestep_q, phasestep_d;
    logic                           phaseloadreg_q, phaseloadreg_d;
    logic                           pll_rst_q, pll_rst_d;
    logic                           ready_q, ready_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           req_ready_q, req_ready_d;
    logic                           enter_step;
    logic                           wait_lock;
    logic                           lock_ok;
    logic                           lock_lost;

    assign wait_lock = (state_q == WAIT_LOCK);

    pll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .count_en  (wait_lock),
        .armed     (ready_q),
        .lock_ok   (lock_ok),
        .lock_lost (lock_lost)
    );

    function automatic logic [PHASE_W-1:0] step_phase(input logic [PHASE_W-1:0] p,
                                                      input logic up);
        if (up) begin
            return (p == PHASE_W'(PHASE_MOD - 1)) ? '0 : p + PHASE_W'(1);
        end
        return (p == '0) ? PHASE_W'(PHASE_MOD - 1) : p - PHASE_W'(1);
    endfunction

    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        tmr_d          = tmr_q;
        rem_d          = rem_q;
        phase_d        = phase_q;
        loss_d         = loss_q;
        phasesel_d     = phasesel_q;
        phasedir_d     = phasedir_q;
        ready_d        = ready_q;
        phaseloadreg_d = 1'b1;
        done_d         = 1'b0;
        err_d          = 1'b0;
        enter_step     = 1'b0;

        // Lock loss overrides everything, including a coincident transfer.
        if (lock_lost) begin
            state_d   = RST_PLL;
            rst_cnt_d = '0;
            tmr_d     = '0;
            phase_d   = '0;
            ready_d   = 1'b0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                RST_PLL: begin
                    if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RC_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end
                IDLE: begin
                    if (req.req_valid) begin
                        if (32'(req.req_ch) >= NUM_CH) begin
                            err_d = 1'b1;
                        end else if (req.req_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            phasesel_d = req.req_ch;
                            phasedir_d = req.req_dir;
                            rem_d      = req.req_count;
                            tmr_d      = '0;
                            state_d    = SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (tmr_q == TMR_W'(STEP_GAP - 1)) begin
                        tmr_d      = '0;
                        state_d    = STEP;
                        enter_step = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                STEP: begin
                    if (tmr_q == TMR_W'(STEP_HI - 1)) begin
                        tmr_d   = '0;
                        state_d = GAP;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (tmr_q == TMR_W'(STEP_GAP - 1)) begin
                        tmr_d = '0;
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = STEP;
                            enter_step = 1'b1;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: state_d = RST_PLL;
            endcase
        end

        if (enter_step) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (phasesel_q == 2'(i)) begin
                    phase_d[i] = step_phase(phase_q[i], phasedir_q);
                end
            end
        end

        // Status outputs follow the next state so they register in step with it.
        pll_rst_d   = (state_d == RST_PLL);
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d inside {SETUP, STEP, GAP});
        phasestep_d = (state_d != STEP);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= RST_PLL;
            rst_cnt_q      <= '0;
            tmr_q          <= '0;
            rem_q          <= '0;
            phase_q        <= '0;
            loss_q         <= '0;
            phasesel_q     <= SEL_CLKOS;
            phasedir_q     <= 1'b0;
            phasestep_q    <= 1'b1;
            phaseloadreg_q <= 1'b1;
            pll_rst_q      <= 1'b1;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            req_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            tmr_q          <= tmr_d;
            rem_q          <= rem_d;
            phase_q        <= phase_d;
            loss_q         <= loss_d;
            phasesel_q     <= phasesel_d;
            phasedir_q     <= phasedir_d;
            phasestep_q    <= phasestep_d;
            phaseloadreg_q <= phaseloadreg_d;
            pll_rst_q      <= pll_rst_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            req_ready_q    <= req_ready_d;
        end
    end

    assign req.req_ready  = req_ready_q;
    assign phasesel       = phasesel_q;
    assign phasedir       = phasedir_q;
    assign phasestep      = phasestep_q;
    assign phaseloadreg   = phaseloadreg_q;
    assign pll_rst        = pll_rst_q;
    assign ready          = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign phase          = phase_q;
    assign lock_loss_cnt  = loss_q;

endmodule
